// File: rtl/rv2t_fetch_aligner_pkg.sv
// Shared definitions for the fetch aligner: halfword width, RVC detect and reset PC default.
package rv2t_fetch_aligner_pkg;

  localparam int          HALF_W           = 16;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    EX_WAIT,
    EX_HALF,
    EX_SPAN,
    EX_SKIP,
    EX_LOW,
    EX_FULL
  } ex_case_e;

  function automatic logic is_compressed(input logic [HALF_W-1:0] h);
    return h[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/rv2t_fetch_aligner_if.sv
// Fetch-word input, redirect and instruction output bundle of the aligner.
interface rv2t_fetch_aligner_if;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        word_valid_i;
  logic [31:0] word_data_i;
  logic        word_ready_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        is_compressed_o;

  modport slave (
    input  flush_i, flush_pc_i, word_valid_i, word_data_i, instr_ready_i,
    output word_ready_o, instr_valid_o, instr_o, instr_pc_o, is_compressed_o
  );

  modport master (
    output flush_i, flush_pc_i, word_valid_i, word_data_i, instr_ready_i,
    input  word_ready_o, instr_valid_o, instr_o, instr_pc_o, is_compressed_o
  );
endinterface

// File: rtl/rv2t_fetch_aligner.sv
// Realigns word-aligned fetch words into halfword-aligned RVC / 32-bit instructions,
// carrying an upper-halfword leftover across words for spanning instructions.
module rv2t_fetch_aligner
  import rv2t_fetch_aligner_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  rv2t_fetch_aligner_if.slave   bus
);

  localparam logic [31:0] PC0 = {RESET_PC[31:1], 1'b0};

  logic [HALF_W-1:0] r_half;
  logic              r_half_vld;
  logic [31:0]       r_pc;
  logic              r_skip_low;
  logic              r_out_vld;
  logic [31:0]       r_instr;
  logic [31:0]       r_instr_pc;
  logic              r_cmp;

  logic              w_can_load;
  ex_case_e          w_case;
  logic              w_emit;
  logic              w_take;
  logic [31:0]       w_instr;
  logic [31:0]       w_pc_step;
  logic [HALF_W-1:0] w_half_n;
  logic              w_half_vld_n;
  logic [HALF_W-1:0] w_lo;
  logic [HALF_W-1:0] w_hi;

  assign w_can_load = !r_out_vld || bus.instr_ready_i;
  assign w_lo       = bus.word_data_i[15:0];
  assign w_hi       = bus.word_data_i[31:16];

  // Skipping the low half of a redirect word emits nothing, so it may proceed
  // even while the output register is stalled.
  always_comb begin
    w_case = EX_WAIT;
    if (r_half_vld) begin
      if (is_compressed(r_half)) begin
        if (w_can_load) w_case = EX_HALF;
      end else if (bus.word_valid_i && w_can_load) begin
        w_case = EX_SPAN;
      end
    end else if (bus.word_valid_i) begin
      if (r_skip_low)      w_case = EX_SKIP;
      else if (w_can_load) w_case = is_compressed(w_lo) ? EX_LOW : EX_FULL;
    end
  end

  always_comb begin
    w_emit       = 1'b0;
    w_take       = 1'b0;
    w_instr      = '0;
    w_pc_step    = '0;
    w_half_n     = r_half;
    w_half_vld_n = r_half_vld;
    case (w_case)
      EX_HALF: begin
        w_emit       = 1'b1;
        w_instr      = {16'h0, r_half};
        w_pc_step    = 32'd2;
        w_half_vld_n = 1'b0;
      end
      EX_SPAN: begin
        w_emit    = 1'b1;
        w_take    = 1'b1;
        w_instr   = {w_lo, r_half};
        w_pc_step = 32'd4;
        w_half_n  = w_hi;
      end
      EX_SKIP: begin
        w_take       = 1'b1;
        w_half_n     = w_hi;
        w_half_vld_n = 1'b1;
      end
      EX_LOW: begin
        w_emit       = 1'b1;
        w_take       = 1'b1;
        w_instr      = {16'h0, w_lo};
        w_pc_step    = 32'd2;
        w_half_n     = w_hi;
        w_half_vld_n = 1'b1;
      end
      EX_FULL: begin
        w_emit    = 1'b1;
        w_take    = 1'b1;
        w_instr   = bus.word_data_i;
        w_pc_step = 32'd4;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_half     <= '0;
      r_half_vld <= 1'b0;
      r_pc       <= PC0;
      r_skip_low <= RESET_PC[1];
      r_out_vld  <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_cmp      <= 1'b0;
    end else if (bus.flush_i) begin
      r_half_vld <= 1'b0;
      r_pc       <= {bus.flush_pc_i[31:1], 1'b0};
      r_skip_low <= bus.flush_pc_i[1];
      r_out_vld  <= 1'b0;
    end else begin
      r_half     <= w_half_n;
      r_half_vld <= w_half_vld_n;
      r_pc       <= r_pc + w_pc_step;
      if (w_case == EX_SKIP) r_skip_low <= 1'b0;
      if (w_can_load) begin
        r_out_vld <= w_emit;
        if (w_emit) begin
          r_instr    <= w_instr;
          r_instr_pc <= r_pc;
          r_cmp      <= is_compressed(w_instr[15:0]);
        end
      end
    end
  end

  assign bus.word_ready_o    = w_take && !bus.flush_i;
  assign bus.instr_valid_o   = r_out_vld;
  assign bus.instr_o         = r_instr;
  assign bus.instr_pc_o      = r_instr_pc;
  assign bus.is_compressed_o = r_cmp;

endmodule

// File: tb/tb_rv2t_fetch_aligner.sv
// Scoreboard bench for rv2t_fetch_aligner: an address-walking halfword model predicts
// the instruction stream; a negedge monitor pops and compares on each output handshake.
module tb_rv2t_fetch_aligner;

  typedef logic [31:0] wq_t[$];
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        cmp;
  } exp_t;

  logic clk;
  logic reset;
  rv2t_fetch_aligner_if bus();

  rv2t_fetch_aligner #(.RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  logic rand_mode = 1'b0;
  logic bp_hold   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the halfword image from the start PC; an instruction is
  // expected only if all of its halfwords lie inside the delivered words.
  function automatic void build_exp(input logic [31:0] spc, input wq_t w);
    logic [15:0] hv[$];
    logic [31:0] base, p;
    int unsigned idx, n;
    exp_t e;
    base = spc & 32'hFFFF_FFFC;
    p    = spc & 32'hFFFF_FFFE;
    foreach (w[i]) begin
      hv.push_back(w[i][15:0]);
      hv.push_back(w[i][31:16]);
    end
    n = hv.size();
    for (int k = 0; k < 64; k++) begin
      idx = (p - base) >> 1;
      if (idx >= n) break;
      if (hv[idx][1:0] != 2'b11) begin
        e.instr = {16'h0, hv[idx]}; e.pc = p; e.cmp = 1'b1; p = p + 32'd2;
      end else if (idx + 1 < n) begin
        e.instr = {hv[idx+1], hv[idx]}; e.pc = p; e.cmp = 1'b0; p = p + 32'd4;
      end else begin
        break;
      end
      exp_q.push_back(e);
    end
  endfunction

  task automatic send_words(input wq_t w);
    logic acc;
    int   t;
    foreach (w[i]) begin
      if (rand_mode) begin
        bus.word_valid_i = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      bus.word_valid_i = 1'b1;
      bus.word_data_i  = w[i];
      t = 0;
      do begin
        @(negedge clk);
        acc = bus.word_ready_o;
        step();
        t++;
      end while (!acc && t < 200);
      if (!acc) begin
        n_tests++; n_fail++;
        $display("FAIL word_accept_timeout word=%h required=accepted", w[i]);
      end
    end
    bus.word_valid_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin step(); t++; end
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic flush_to(input logic [31:0] pc);
    bus.flush_i      = 1'b1;
    bus.flush_pc_i   = pc;
    bus.word_valid_i = 1'b0;
    @(negedge clk);
    chk("flush_word_ready", {31'h0, bus.word_ready_o}, 32'h0);
    step();
    bus.flush_i = 1'b0;
    chk("flush_valid_clr", {31'h0, bus.instr_valid_o}, 32'h0);
  endtask

  task automatic run_segment(input logic [31:0] spc, input wq_t w, input logic do_flush);
    if (do_flush) flush_to(spc);
    build_exp(spc, w);
    send_words(w);
    drain();
  endtask

  task automatic bp_check();
    int t = 0;
    do begin @(negedge clk); t++; end while (!bus.instr_valid_o && t < 50);
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid",      {31'h0, bus.instr_valid_o}, 32'h1);
      chk("bp_word_ready", {31'h0, bus.word_ready_o},  32'h0);
      chk("bp_pc",         bus.instr_pc_o,             32'h200);
      chk("bp_instr",      bus.instr_o,                32'h13);
      if (k < 2) @(negedge clk);
    end
    bp_hold = 1'b0;
  endtask

  initial begin
    bus.instr_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.instr_ready_i = bp_hold ? 1'b0 : (rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: pop on handshake; also require stable output while stalled.
  logic        pv, pr, pf;
  logic [31:0] p_instr, p_pc;
  initial pv = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr && !pf) begin
        chk("stall_valid", {31'h0, bus.instr_valid_o}, 32'h1);
        chk("stall_instr", bus.instr_o, p_instr);
        chk("stall_pc",    bus.instr_pc_o, p_pc);
      end
      if (bus.instr_valid_o && bus.instr_ready_i) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_instr actual=%h@%h required=none", bus.instr_o, bus.instr_pc_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("instr", bus.instr_o, e.instr);
          chk("pc",    bus.instr_pc_o, e.pc);
          chk("cmp",   {31'h0, bus.is_compressed_o}, {31'h0, e.cmp});
        end
      end
      pv = bus.instr_valid_o; pr = bus.instr_ready_i; pf = bus.flush_i;
      p_instr = bus.instr_o; p_pc = bus.instr_pc_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired required=finish");
    $fatal(1);
  end

  initial begin
    wq_t w;
    logic [31:0] spc;
    logic [15:0] h;
    reset            = 1'b1;
    bus.flush_i      = 1'b0;
    bus.flush_pc_i   = '0;
    bus.word_valid_i = 1'b0;
    bus.word_data_i  = '0;
    repeat (3) step();
    chk("rst_valid", {31'h0, bus.instr_valid_o}, 32'h0);
    chk("rst_instr", bus.instr_o, 32'h0);
    chk("rst_pc",    bus.instr_pc_o, 32'h0);
    chk("rst_cmp",   {31'h0, bus.is_compressed_o}, 32'h0);
    reset = 1'b0;
    step();

    run_segment(32'h0, '{32'h0000_0013, 32'h00A0_0093}, 1'b0);
    run_segment(32'h0, '{32'h4505_0001}, 1'b1);
    run_segment(32'h0, '{32'h0093_0001, 32'h1234_00A0}, 1'b1);
    // leave a non-compressed half pending, then redirect to an odd-halfword target
    run_segment(32'h40, '{32'hFFFF_0001}, 1'b1);
    run_segment(32'h103, '{32'h4505_FFFF}, 1'b1);
    run_segment(32'hFFFF_FFFA, '{32'h0013_FFFF, 32'h0001_0000, 32'h0000_0013}, 1'b1);

    bp_hold = 1'b1;
    flush_to(32'h200);
    w = '{32'h0000_0013, 32'h00A0_0093, 32'h4505_0001};
    build_exp(32'h200, w);
    fork
      send_words(w);
      bp_check();
    join
    drain();

    // async reset between halves of a spanning instruction
    run_segment(32'h80, '{32'h0093_0001}, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'h0, bus.instr_valid_o}, 32'h0);
    chk("arst_instr", bus.instr_o, 32'h0);
    chk("arst_pc",    bus.instr_pc_o, 32'h0);
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
    step();
    run_segment(32'h0, '{32'h1234_00A0}, 1'b0);

    rand_mode = 1'b1;
    for (int s = 0; s < 40; s++) begin
      w.delete();
      for (int i = 0; i < $urandom_range(1, 6); i++) begin
        logic [31:0] wd;
        for (int j = 0; j < 2; j++) begin
          h = 16'($urandom);
          if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
          if (j == 0) wd[15:0] = h; else wd[31:16] = h;
        end
        w.push_back(wd);
      end
      if ($urandom_range(0, 4) == 0) spc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 7) * 2);
      else spc = {$urandom(), 1'b0} & 32'hFFFF_FFFE;
      run_segment(spc, w, 1'b1);
    end
    rand_mode = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
